// File: rtl/dma_pacer_if.sv
// -----------------------------------------------------------------------------
// dma_pacer_if
//
// Bundles the ZX-Uno register bus, the timebase tick and the DMA handshake
// of the DMA pacer into one interface.
//
// Signals:
//   clk28en      timebase tick, one clk cycle wide
//   zxuno_addr   currently selected ZX-Uno register
//   zxuno_regrd  register read strobe
//   zxuno_regwr  register write strobe, one cycle per write
//   din          register write data
//   dout         register read data (8'h00 when not selected)
//   oe           high while dout carries a read of a pacer register
//   xfer_done    one-cycle pulse from the DMA when a paced transfer completes
//   trigger      one-cycle pulse requesting one DMA transfer
//   pending      a trigger has been issued and not yet serviced
//
// Modports:
//   master  CPU/DMA side that drives the bus and consumes the triggers
//   slave   the pacer itself
// -----------------------------------------------------------------------------
interface dma_pacer_if;
  logic       clk28en;
  logic [7:0] zxuno_addr;
  logic       zxuno_regrd;
  logic       zxuno_regwr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       oe;
  logic       xfer_done;
  logic       trigger;
  logic       pending;

  modport master (
    output clk28en, zxuno_addr, zxuno_regrd, zxuno_regwr, din, xfer_done,
    input  dout, oe, trigger, pending
  );

  modport slave (
    input  clk28en, zxuno_addr, zxuno_regrd, zxuno_regwr, din, xfer_done,
    output dout, oe, trigger, pending
  );
endinterface : dma_pacer_if

// File: rtl/dma_pacer.sv
// -----------------------------------------------------------------------------
// dma_pacer
//
// Programmable periodic trigger source for the DMA engine. A 16-bit
// down-counter advances on each clk28en tick; when it is observed at zero it
// reloads, emits a one-cycle trigger and marks the trigger pending until the
// DMA reports xfer_done. A new trigger while the previous one is still
// pending sets a sticky overrun flag.
//
// Registers (ZX-Uno register interface):
//   REG_PRELO  reload[7:0]                               (rw)
//   REG_PREHI  reload[15:8]                              (rw)
//   REG_CTRL   write: din[0]=EN, din[1]=ONESHOT, din[7]=clear overrun
//              read : {overrun, pending, 4'b0, ONESHOT, EN}
//   REG_MISS   saturating missed-trigger count            (ro, optional)
//
// Ports:
//   clk   system clock, the only clock
//   rst   synchronous active-high reset
//   bus   dma_pacer_if.slave: register bus, tick and DMA handshake
//
// Build option:
//   DMA_PACER_MISSCNT_EN  when defined, compiles in the 8-bit saturating miss
//                         counter readable at REG_MISS. When undefined that
//                         address is not decoded.
// -----------------------------------------------------------------------------
module dma_pacer #(
  parameter logic [7:0] REG_PRELO = 8'hA3,
  parameter logic [7:0] REG_PREHI = 8'hA4,
  parameter logic [7:0] REG_CTRL  = 8'hA5,
  parameter logic [7:0] REG_MISS  = 8'hA6
) (
  input  logic        clk,
  input  logic        rst,
  dma_pacer_if.slave  bus
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [15:0] reload_q, reload_d;
  logic [15:0] cnt_q,    cnt_d;
  logic        en_q,     en_d;
  logic        one_q,    one_d;
  logic        pend_q,   pend_d;
  logic        ovr_q,    ovr_d;
  logic        trig_q;
`ifdef DMA_PACER_MISSCNT_EN
  logic [7:0]  miss_q,   miss_d;
`endif

  // Counter reached zero on a live tick this cycle.
  logic        wrap;

  // ---------------------------------------------------------------------------
  // Register write decode
  // ---------------------------------------------------------------------------
  logic wr_prelo;
  logic wr_prehi;
  logic wr_ctrl;

  assign wr_prelo = bus.zxuno_regwr && (bus.zxuno_addr == REG_PRELO);
  assign wr_prehi = bus.zxuno_regwr && (bus.zxuno_addr == REG_PREHI);
  assign wr_ctrl  = bus.zxuno_regwr && (bus.zxuno_addr == REG_CTRL);

  // ---------------------------------------------------------------------------
  // Next-state logic
  //
  // A register write in a tick cycle owns the counter: the tick is dropped,
  // so there is neither a decrement nor a trigger in that cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block is assigned a default first so that no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    reload_d = reload_q;
    cnt_d    = cnt_q;
    en_d     = en_q;
    one_d    = one_q;
    pend_d   = pend_q;
    ovr_d    = ovr_q;
    wrap     = 1'b0;
`ifdef DMA_PACER_MISSCNT_EN
    miss_d   = miss_q;
`endif

    if (wr_prelo) begin
      reload_d[7:0] = bus.din;
      // While stopped the counter follows reload immediately; while running
      // the new value is picked up at the next wrap.
      if (!en_q) begin
        cnt_d = {reload_q[15:8], bus.din};
      end
    end else if (wr_prehi) begin
      reload_d[15:8] = bus.din;
      if (!en_q) begin
        cnt_d = {bus.din, reload_q[7:0]};
      end
    end else if (wr_ctrl) begin
      en_d  = bus.din[0];
      one_d = bus.din[1];
      // Only a 0->1 transition of EN restarts the period.
      if (bus.din[0] && !en_q) begin
        cnt_d = reload_q;
      end
      if (bus.din[7]) begin
        ovr_d  = 1'b0;
`ifdef DMA_PACER_MISSCNT_EN
        miss_d = 8'h00;
`endif
      end
    end else if (en_q && bus.clk28en) begin
      if (cnt_q == 16'h0000) begin
        wrap = 1'b1;
      end else begin
        cnt_d = cnt_q - 16'd1;
      end
    end

    if (wrap) begin
      cnt_d  = reload_q;
      pend_d = 1'b1;
      if (one_q) begin
        en_d = 1'b0;
      end
      // A coincident xfer_done services the old trigger, so only an
      // unserviced pending trigger counts as an overrun.
      if (pend_q && !bus.xfer_done) begin
        ovr_d = 1'b1;
`ifdef DMA_PACER_MISSCNT_EN
        if (miss_q != 8'hFF) begin
          miss_d = miss_q + 8'd1;
        end
`endif
      end
    end else if (bus.xfer_done) begin
      pend_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample their next value from the same pre-edge snapshot.
    if (rst) begin
      reload_q <= 16'hFFFF;
      cnt_q    <= 16'hFFFF;
      en_q     <= 1'b0;
      one_q    <= 1'b0;
      pend_q   <= 1'b0;
      ovr_q    <= 1'b0;
      trig_q   <= 1'b0;
`ifdef DMA_PACER_MISSCNT_EN
      miss_q   <= 8'h00;
`endif
    end else begin
      reload_q <= reload_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      one_q    <= one_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      trig_q   <= wrap;
`ifdef DMA_PACER_MISSCNT_EN
      miss_q   <= miss_d;
`endif
    end
  end

  assign bus.trigger = trig_q;
  assign bus.pending = pend_q;

  // ---------------------------------------------------------------------------
  // Register read mux (combinational)
  // ---------------------------------------------------------------------------
  logic       rd_hit;
  logic [7:0] rd_data;

  always_comb begin
    rd_hit  = 1'b0;
    rd_data = 8'h00;
    if (bus.zxuno_regrd) begin
      if (bus.zxuno_addr == REG_PRELO) begin
        rd_hit  = 1'b1;
        rd_data = reload_q[7:0];
      end else if (bus.zxuno_addr == REG_PREHI) begin
        rd_hit  = 1'b1;
        rd_data = reload_q[15:8];
      end else if (bus.zxuno_addr == REG_CTRL) begin
        rd_hit  = 1'b1;
        rd_data = {ovr_q, pend_q, 4'b0000, one_q, en_q};
`ifdef DMA_PACER_MISSCNT_EN
      end else if (bus.zxuno_addr == REG_MISS) begin
        rd_hit  = 1'b1;
        rd_data = miss_q;
`else
      end else if (bus.zxuno_addr == REG_MISS) begin
        // Miss counter not built: the address reads as unimplemented.
        rd_hit  = 1'b0;
        rd_data = 8'h00;
`endif
      end
    end
  end

  assign bus.oe   = rd_hit;
  assign bus.dout = rd_data;

endmodule : dma_pacer
